// File: rtl/cgram_port_pkg.sv
// Purpose: shared types and constants for the CGRAM palette port.
//   - CPU register offsets (low byte of $21xx)
//   - cgram_wr_type: one deferred palette word write {addr, data}
//   - cg_read_byte: byte lane selection for $213B reads
package cgram_port_pkg;

   localparam int unsigned CG_AW    = 8;
   localparam int unsigned CG_DW    = 15;
   localparam int unsigned CG_WORDS = 1 << CG_AW;

   localparam logic [7:0] CGADD      = 8'h21;
   localparam logic [7:0] CGDATA     = 8'h22;
   localparam logic [7:0] CGDATAREAD = 8'h3B;

   typedef struct packed {
      logic [CG_AW-1:0] addr;
      logic [CG_DW-1:0] data;
   } cgram_wr_type;

   // High byte carries only 7 palette bits; bit 7 comes from PPU2 open bus.
   function automatic logic [7:0] cg_read_byte(input logic [CG_DW-1:0] word,
                                               input logic             hi,
                                               input logic             ob7);
      return hi ? {ob7, word[14:8]} : word[7:0];
   endfunction

endpackage

// File: rtl/cgram_port_if.sv
// Purpose: CPU register bus for the CGRAM port.
//   cpu_we/cpu_re    one-cycle write/read strobes
//   cpu_reg          low byte of the $21xx register address
//   cpu_wdata        write data
//   ppu2_openbus7    open-bus bit returned as bit 7 of a high-byte read
//   cpu_rdata        read data, valid while cpu_rvalid pulses
interface cgram_port_if;
   logic       cpu_we;
   logic       cpu_re;
   logic [7:0] cpu_reg;
   logic [7:0] cpu_wdata;
   logic       ppu2_openbus7;
   logic [7:0] cpu_rdata;
   logic       cpu_rvalid;

   modport master (
      output cpu_we, cpu_re, cpu_reg, cpu_wdata, ppu2_openbus7,
      input  cpu_rdata, cpu_rvalid
   );

   modport slave (
      input  cpu_we, cpu_re, cpu_reg, cpu_wdata, ppu2_openbus7,
      output cpu_rdata, cpu_rvalid
   );
endinterface

// File: rtl/cgram_pend_fifo.sv
// Purpose: small FIFO of deferred CGRAM word writes with a newest-match
// address lookup so CPU reads see data that has not yet reached the RAM.
//   clk, reset_n      clock, async active-low reset (discards entries)
//   push_i/entry_i    enqueue one write (ignored when full)
//   pop_i/head_o      dequeue the oldest write (ignored when empty)
//   empty_o/full_o    occupancy flags
//   lookup_addr_i     address to search
//   hit_o/hit_data_o  newest queued data for lookup_addr_i
module cgram_pend_fifo
   import cgram_port_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  cgram_wr_type     entry_i,
   input  logic             pop_i,
   output cgram_wr_type     head_o,
   output logic             empty_o,
   output logic             full_o,
   input  logic [CG_AW-1:0] lookup_addr_i,
   output logic             hit_o,
   output logic [CG_DW-1:0] hit_data_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   cgram_wr_type  mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;
   logic [PW-1:0] lk_idx;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign head_o  = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy next-state.
   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage needs no reset: occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= entry_i;
   end

   // Walk from oldest to newest so the last match wins.
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      lk_idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         lk_idx = PW'((32'(rd_q) + i) % DEPTH);
         if ((32'(i) < 32'(cnt_q)) && (mem_q[lk_idx].addr == lookup_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = mem_q[lk_idx].data;
         end
      end
   end

endmodule

// File: rtl/cgram_port.sv
// Purpose: owns the 256x15 CGRAM, serves the pixel mixer read port and the
// CPU palette registers ($2121 CGADD, $2122 CGDATA, $213B CGDATAREAD).
// CPU word writes that land while the mixer owns the RAM are parked in a
// pending FIFO and retired when the port is idle.
//   clk, reset_n    clock, async active-low reset
//   bus             CPU register interface (slave side)
//   render_active   mixer owns the single RAM port this cycle
//   pix_addr        mixer palette address
//   pix_rdata       ram[pix_addr] one cycle later (held when not rendering)
//   pend_overflow   sticky: a deferred write was dropped, cleared by $2121
module cgram_port
   import cgram_port_pkg::*;
#(
   parameter int unsigned PEND_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   cgram_port_if.slave      bus,
   input  logic             render_active,
   input  logic [CG_AW-1:0] pix_addr,
   output logic [CG_DW-1:0] pix_rdata,
   output logic             pend_overflow
);

   logic [CG_DW-1:0] ram_q [CG_WORDS];

   logic [CG_AW-1:0] word_addr_q, word_addr_d;
   logic             hi_q, hi_d;
   logic [7:0]       low_q, low_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic [CG_DW-1:0] pix_q, pix_d;
   logic             ovf_q, ovf_d;

   logic             wr_addr_c, wr_data_c, rd_c, commit_c;
   logic             direct_c, push_c, drop_c, pop_c;
   logic             ram_we_c;
   logic [CG_AW-1:0] ram_waddr_c, ram_raddr_c;
   logic [CG_DW-1:0] ram_wdata_c, ram_rword_c, cpu_word_c, commit_word_c;

   cgram_wr_type     push_entry_c, head;
   logic             fifo_empty, fifo_full, fwd_hit;
   logic [CG_DW-1:0] fwd_data;

   cgram_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend (
      .clk           (clk),
      .reset_n       (reset_n),
      .push_i        (push_c),
      .entry_i       (push_entry_c),
      .pop_i         (pop_c),
      .head_o        (head),
      .empty_o       (fifo_empty),
      .full_o        (fifo_full),
      .lookup_addr_i (word_addr_q),
      .hit_o         (fwd_hit),
      .hit_data_o    (fwd_data)
   );

   // Port arbitration: mixer > CPU read > FIFO drain. A direct CPU write
   // only happens with an empty FIFO, so it never collides with a drain.
   always_comb begin
      wr_addr_c     = bus.cpu_we && (bus.cpu_reg == CGADD);
      wr_data_c     = bus.cpu_we && (bus.cpu_reg == CGDATA);
      rd_c          = bus.cpu_re && !bus.cpu_we && (bus.cpu_reg == CGDATAREAD);
      commit_c      = wr_data_c && hi_q;
      commit_word_c = {bus.cpu_wdata[6:0], low_q};

      direct_c = commit_c && !render_active && fifo_empty;
      push_c   = commit_c && !direct_c && !fifo_full;
      drop_c   = commit_c && !direct_c && fifo_full;
      pop_c    = !render_active && !rd_c && !fifo_empty;

      push_entry_c.addr = word_addr_q;
      push_entry_c.data = commit_word_c;

      ram_we_c    = direct_c || pop_c;
      ram_waddr_c = pop_c ? head.addr : word_addr_q;
      ram_wdata_c = pop_c ? head.data : commit_word_c;

      // While rendering the CPU sees whatever the pixel port is fetching.
      ram_raddr_c = render_active ? pix_addr : word_addr_q;
      ram_rword_c = ram_q[ram_raddr_c];
      cpu_word_c  = (!render_active && fwd_hit) ? fwd_data : ram_rword_c;
   end

   // Register next-state.
   always_comb begin
      word_addr_d = word_addr_q;
      hi_d        = hi_q;
      low_d       = low_q;
      rdata_d     = rdata_q;
      rvalid_d    = rd_c;
      ovf_d       = ovf_q;
      pix_d       = render_active ? ram_rword_c : pix_q;

      if (wr_addr_c) begin
         word_addr_d = bus.cpu_wdata;
         hi_d        = 1'b0;
         ovf_d       = 1'b0;
      end else if (wr_data_c) begin
         if (!hi_q) begin
            low_d = bus.cpu_wdata;
            hi_d  = 1'b1;
         end else begin
            word_addr_d = word_addr_q + CG_AW'(1);
            hi_d        = 1'b0;
            if (drop_c) ovf_d = 1'b1;
         end
      end else if (rd_c) begin
         rdata_d = cg_read_byte(cpu_word_c, hi_q, bus.ppu2_openbus7);
         hi_d    = !hi_q;
         if (hi_q) word_addr_d = word_addr_q + CG_AW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_addr_q <= '0;
         hi_q        <= 1'b0;
         low_q       <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         pix_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         word_addr_q <= word_addr_d;
         hi_q        <= hi_d;
         low_q       <= low_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         pix_q       <= pix_d;
         ovf_q       <= ovf_d;
      end
   end

   // Palette storage, intentionally not reset.
   always_ff @(posedge clk) begin
      if (ram_we_c) ram_q[ram_waddr_c] <= ram_wdata_c;
   end

   assign bus.cpu_rdata  = rdata_q;
   assign bus.cpu_rvalid = rvalid_q;
   assign pix_rdata      = pix_q;
   assign pend_overflow  = ovf_q;

endmodule

// File: tb/tb_cgram_port.sv
module tb_cgram_port;
   import cgram_port_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        render_active;
   logic [7:0]  pix_addr;
   logic [14:0] pix_rdata;
   logic        pend_overflow;

   cgram_port_if bus();

   cgram_port #(.PEND_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .render_active (render_active),
      .pix_addr      (pix_addr),
      .pix_rdata     (pix_rdata),
      .pend_overflow (pend_overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n)
         assert (!(bus.cpu_we && bus.cpu_re))
            else $error("protocol: cpu_we and cpu_re asserted together");
   end

   int checks = 0;
   int failures = 0;

   // Reference model: palette array, queue of deferred writes, CPU-side state.
   logic [14:0]  m_ram [256];
   cgram_wr_type m_q [$];
   logic [7:0]   m_wa, m_low, m_rdata;
   logic         m_hi, m_ovf, m_rvalid;
   logic [14:0]  m_pix;

   typedef struct {
      logic       we, re;
      logic [7:0] rg, wd;
      logic       ob7, ra;
      logic [7:0] pa;
      logic       chk_rd;
      logic [7:0] exp_rd;
      logic       exp_ovf;
      logic       chk_pix;
      logic [14:0] exp_pix;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_wa = 8'h00; m_low = 8'h00; m_rdata = 8'h00;
      m_hi = 1'b0; m_ovf = 1'b0; m_rvalid = 1'b0; m_pix = 15'h0;
   endfunction

   // One clock of architectural behaviour, evaluated from the pre-edge inputs.
   function automatic void model_step();
      int           sz0;
      logic         rd, pushing;
      logic [14:0]  word;
      cgram_wr_type ent;
      sz0     = m_q.size();
      rd      = bus.cpu_re && !bus.cpu_we && (bus.cpu_reg == 8'h3B);
      pushing = 1'b0;
      ent     = '0;
      m_rvalid = 1'b0;
      if (render_active) m_pix = m_ram[pix_addr];
      if (bus.cpu_we && bus.cpu_reg == 8'h21) begin
         m_wa = bus.cpu_wdata; m_hi = 1'b0; m_ovf = 1'b0;
      end else if (bus.cpu_we && bus.cpu_reg == 8'h22) begin
         if (!m_hi) begin
            m_low = bus.cpu_wdata; m_hi = 1'b1;
         end else begin
            word = {bus.cpu_wdata[6:0], m_low};
            if (!render_active && sz0 == 0) m_ram[m_wa] = word;
            else if (sz0 < DEPTH) begin
               pushing = 1'b1; ent.addr = m_wa; ent.data = word;
            end else m_ovf = 1'b1;
            m_wa = m_wa + 8'd1;
            m_hi = 1'b0;
         end
      end else if (rd) begin
         if (render_active) word = m_ram[pix_addr];
         else begin
            word = m_ram[m_wa];
            foreach (m_q[i]) if (m_q[i].addr == m_wa) word = m_q[i].data;
         end
         if (m_hi) begin
            m_rdata = {bus.ppu2_openbus7, word[14:8]};
            m_wa = m_wa + 8'd1;
         end else m_rdata = word[7:0];
         m_hi = !m_hi;
         m_rvalid = 1'b1;
      end
      if (!render_active && !rd && sz0 > 0) begin
         m_ram[m_q[0].addr] = m_q[0].data;
         void'(m_q.pop_front());
      end
      if (pushing) m_q.push_back(ent);
   endfunction

   task automatic drive(input logic we, input logic re, input logic [7:0] rg,
                        input logic [7:0] wd, input logic ob7, input logic ra,
                        input logic [7:0] pa);
      bus.cpu_we = we; bus.cpu_re = re; bus.cpu_reg = rg; bus.cpu_wdata = wd;
      bus.ppu2_openbus7 = ob7; render_active = ra; pix_addr = pa;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("rvalid", 16'(bus.cpu_rvalid), 16'(m_rvalid));
      chk("rdata", 16'(bus.cpu_rdata), 16'(m_rdata));
      chk("pix_rdata", 16'(pix_rdata), 16'(m_pix));
      chk("pend_overflow", 16'(pend_overflow), 16'(m_ovf));
   endtask

   function automatic void addv(input logic we, input logic re, input logic [7:0] rg,
                                input logic [7:0] wd, input logic ob7, input logic ra,
                                input logic [7:0] pa, input logic chk_rd,
                                input logic [7:0] exp_rd, input logic exp_ovf,
                                input logic chk_pix, input logic [14:0] exp_pix);
      vec_t v;
      v.we = we; v.re = re; v.rg = rg; v.wd = wd; v.ob7 = ob7; v.ra = ra; v.pa = pa;
      v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_ovf = exp_ovf;
      v.chk_pix = chk_pix; v.exp_pix = exp_pix;
      vecs.push_back(v);
   endfunction

   function automatic void W(input logic [7:0] rg, input logic [7:0] wd, input logic ra,
                             input logic ovf);
      addv(1'b1, 1'b0, rg, wd, 1'b0, ra, 8'h10, 1'b0, 8'h00, ovf, 1'b0, 15'h0);
   endfunction

   function automatic void R(input logic [7:0] exp, input logic ra, input logic [7:0] pa,
                             input logic ovf);
      addv(1'b0, 1'b1, 8'h3B, 8'h00, 1'b0, ra, pa, 1'b1, exp, ovf, 1'b0, 15'h0);
   endfunction

   function automatic void I(input logic ra, input logic ovf);
      addv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ra, 8'h10, 1'b0, 8'h00, ovf, 1'b0, 15'h0);
   endfunction

   initial begin
      int op;
      logic ra;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("reset rvalid", 16'(bus.cpu_rvalid), 16'h0);
      chk("reset rdata", 16'(bus.cpu_rdata), 16'h0);
      chk("reset pix", 16'(pix_rdata), 16'h0);
      chk("reset ovf", 16'(pend_overflow), 16'h0);
      reset_n = 1'b1;

      // Basic word write, then read back through $213B.
      W(8'h21, 8'h10, 0, 0); W(8'h22, 8'h34, 0, 0); W(8'h22, 8'h92, 0, 0);
      W(8'h21, 8'h10, 0, 0); R(8'h34, 0, 8'h10, 0); R(8'h12, 0, 8'h10, 0);
      // Address wrap 0xFF -> 0x00.
      W(8'h21, 8'hFF, 0, 0); W(8'h22, 8'h11, 0, 0); W(8'h22, 8'h22, 0, 0);
      W(8'h22, 8'h33, 0, 0); W(8'h22, 8'h44, 0, 0);
      W(8'h21, 8'hFF, 0, 0); R(8'h11, 0, 8'h10, 0); R(8'h22, 0, 8'h10, 0);
      R(8'h33, 0, 8'h10, 0); R(8'h44, 0, 8'h10, 0);
      // Three commits while rendering: two buffered, third dropped.
      W(8'h21, 8'h40, 1, 0); W(8'h22, 8'h01, 1, 0); W(8'h22, 8'h01, 1, 0);
      W(8'h22, 8'h02, 1, 0); W(8'h22, 8'h02, 1, 0);
      W(8'h22, 8'h03, 1, 0); W(8'h22, 8'h03, 1, 1);
      I(0, 1); I(0, 1);
      W(8'h21, 8'h40, 0, 0);
      R(8'h01, 0, 8'h10, 0); R(8'h01, 0, 8'h10, 0);
      R(8'h02, 0, 8'h10, 0); R(8'h02, 0, 8'h10, 0);
      // Forwarding from the pending FIFO before drain.
      W(8'h21, 8'h20, 1, 0); W(8'h22, 8'hFF, 1, 0); W(8'h22, 8'h7F, 1, 0);
      W(8'h21, 8'h20, 1, 0);
      R(8'hFF, 0, 8'h10, 0); R(8'h7F, 0, 8'h10, 0);
      I(0, 0);
      W(8'h21, 8'h20, 0, 0); R(8'hFF, 0, 8'h10, 0); R(8'h7F, 0, 8'h10, 0);
      // Pixel port and CPU read during rendering.
      W(8'h21, 8'h05, 0, 0); W(8'h22, 8'hBC, 0, 0); W(8'h22, 8'h0A, 0, 0);
      addv(1'b0, 1'b1, 8'h3B, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 8'hBC, 1'b0, 1'b1, 15'h0ABC);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].we, vecs[i].re, vecs[i].rg, vecs[i].wd, vecs[i].ob7,
               vecs[i].ra, vecs[i].pa);
         tick();
         chk($sformatf("vec%0d rvalid", i), 16'(bus.cpu_rvalid), 16'(vecs[i].chk_rd));
         if (vecs[i].chk_rd)
            chk($sformatf("vec%0d rdata", i), 16'(bus.cpu_rdata), 16'(vecs[i].exp_rd));
         chk($sformatf("vec%0d ovf", i), 16'(pend_overflow), 16'(vecs[i].exp_ovf));
         if (vecs[i].chk_pix)
            chk($sformatf("vec%0d pix", i), 16'(pix_rdata), 16'(vecs[i].exp_pix));
      end

      // Reset mid-sequence: pending entries, overflow and half-written word lost.
      drive(1, 0, 8'h21, 8'h00, 0, 1, 8'h10); tick();
      drive(0, 1, 8'h3B, 8'h00, 0, 1, 8'h10); tick();
      drive(0, 1, 8'h3B, 8'h00, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h21, 8'h00, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h22, 8'h11, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h22, 8'h11, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h22, 8'h22, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h22, 8'h22, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h22, 8'h33, 0, 1, 8'h10); tick();
      drive(1, 0, 8'h22, 8'h33, 0, 1, 8'h10); tick();
      chk("pre-reset ovf", 16'(pend_overflow), 16'h1);
      drive(1, 0, 8'h22, 8'h55, 0, 1, 8'h10); tick();
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async reset rdata", 16'(bus.cpu_rdata), 16'h0);
      chk("async reset pix", 16'(pix_rdata), 16'h0);
      chk("async reset ovf", 16'(pend_overflow), 16'h0);
      @(posedge clk);
      #1;
      chk("held reset rvalid", 16'(bus.cpu_rvalid), 16'h0);
      chk("held reset pix", 16'(pix_rdata), 16'h0);
      reset_n = 1'b1;
      drive(0, 1, 8'h3B, 8'h00, 0, 0, 8'h00); tick();
      chk("post-reset low byte", 16'(bus.cpu_rdata), 16'h33);
      drive(0, 1, 8'h3B, 8'h00, 1, 0, 8'h00); tick();
      chk("post-reset high byte", 16'(bus.cpu_rdata), 16'hC4);

      // Fill every palette entry so random reads have known contents.
      drive(1, 0, 8'h21, 8'h00, 0, 0, 8'h00); tick();
      for (int i = 0; i < 512; i++) begin
         drive(1, 0, 8'h22, 8'($urandom), 0, 0, 8'h00);
         tick();
      end

      // Randomized traffic against the model.
      ra = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) ra = !ra;
         op = int'($urandom_range(0, 99));
         if (op < 20)
            drive(0, 0, 8'h00, 8'($urandom), 1'($urandom), ra, 8'($urandom));
         else if (op < 28)
            drive(1, 0, 8'h21, 8'($urandom), 1'($urandom), ra, 8'($urandom));
         else if (op < 65)
            drive(1, 0, 8'h22, 8'($urandom), 1'($urandom), ra, 8'($urandom));
         else if (op < 93)
            drive(0, 1, 8'h3B, 8'($urandom), 1'($urandom), ra, 8'($urandom));
         else if (op < 97)
            drive(1, 0, 8'h3B, 8'($urandom), 1'($urandom), ra, 8'($urandom));
         else
            drive(0, 1, 8'h22, 8'($urandom), 1'($urandom), ra, 8'($urandom));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
